// File: rtl/axi_write_sequencer.sv
// AXI4 write-burst sequencer: accepts one command, issues a single INCR burst of
// 32-byte beats carrying a counting data pattern, collects the write response
// and reports completion through a valid/ready handshake.
module axi_write_sequencer (
    input  logic         data_aclk,
    input  logic         data_aresetn,
    // command handshake
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [31:0]  cmd_addr,
    input  logic [7:0]   cmd_len,
    input  logic [23:0]  cmd_id,
    input  logic [31:0]  cmd_seed,
    // completion handshake and status
    output logic         done_valid,
    input  logic         done_ready,
    output logic [1:0]   done_resp,
    output logic         done_idmismatch,
    output logic         busy,
    // AXI write address
    output logic [23:0]  data_awid,
    output logic [31:0]  data_awaddr,
    output logic [7:0]   data_awlen,
    output logic [2:0]   data_awsize,
    output logic [1:0]   data_awburst,
    output logic [2:0]   data_awprot,
    output logic [3:0]   data_awqos,
    output logic         data_awvalid,
    input  logic         data_awready,
    // AXI write data
    output logic [255:0] data_wdata,
    output logic [31:0]  data_wstrb,
    output logic         data_wlast,
    output logic         data_wvalid,
    input  logic         data_wready,
    // AXI write response
    input  logic [23:0]  data_bid,
    input  logic [1:0]   data_bresp,
    input  logic         data_bvalid,
    output logic         data_bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // control state
    logic        ready_en;   // holds cmd_ready low until the first edge after reset
    logic [7:0]  beat;

    // registered command and completion status
    logic [31:5] addr_q;
    logic [7:0]  len_q;
    logic [23:0] id_q;
    logic [31:0] seed_q;
    logic [1:0]  resp_q;
    logic        mism_q;

    logic        cmd_fire;
    logic        crosses_4k;
    logic        last_beat;
    logic [8:0]  blk_end;
    logic [31:0] beat_word;
    logic        unused_addr_lsbs;

    // byte offset within the 4 KB page is irrelevant below the 32-byte beat size
    assign unused_addr_lsbs = ^cmd_addr[4:0];

    // burst end in 32-byte units within the 4 KB page; beyond 128 units it crosses
    assign blk_end    = {2'b00, cmd_addr[11:5]} + {1'b0, cmd_len} + 9'd1;
    assign crosses_4k = (blk_end > 9'd128);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign last_beat  = (beat == len_q);
    assign beat_word  = seed_q + {24'd0, beat};

    // state register
    always_ff @(posedge data_aclk or negedge data_aresetn) begin
        if (!data_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode and all handshake/payload outputs
    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        data_awvalid    = 1'b0;
        data_awid       = 24'd0;
        data_awaddr     = 32'd0;
        data_awlen      = 8'd0;
        data_awsize     = 3'd0;
        data_awburst    = 2'b00;
        data_awprot     = 3'd0;
        data_awqos      = 4'd0;
        data_wvalid     = 1'b0;
        data_wdata      = 256'd0;
        data_wstrb      = 32'd0;
        data_wlast      = 1'b0;
        data_bready     = 1'b0;
        done_valid      = 1'b0;
        done_resp       = 2'b00;
        done_idmismatch = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ready_en;
                if (cmd_valid && ready_en) begin
                    state_nxt = crosses_4k ? DONE : ADDR;
                end
            end
            ADDR: begin
                data_awvalid = 1'b1;
                data_awid    = id_q;
                data_awaddr  = {addr_q, 5'b00000};
                data_awlen   = len_q;
                data_awsize  = 3'd5;
                data_awburst = 2'b01;
                if (data_awready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                data_wvalid = 1'b1;
                data_wdata  = {8{beat_word}};
                data_wstrb  = 32'hFFFF_FFFF;
                data_wlast  = last_beat;
                if (data_wready && last_beat) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                data_bready = 1'b1;
                if (data_bvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_valid      = 1'b1;
                done_resp       = resp_q;
                done_idmismatch = mism_q;
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // command-ready enable and beat counter
    always_ff @(posedge data_aclk or negedge data_aresetn) begin
        if (!data_aresetn) begin
            ready_en <= 1'b0;
            beat     <= 8'd0;
        end else begin
            ready_en <= 1'b1;
            if (state == ADDR) begin
                beat <= 8'd0;
            end else if (state == DATA && data_wready && !last_beat) begin
                // the final beat leaves the counter alone, so len=255 never wraps
                beat <= beat + 8'd1;
            end
        end
    end

    // command capture and completion status; only visible through state-gated outputs
    always_ff @(posedge data_aclk) begin
        if (state == IDLE && cmd_fire) begin
            addr_q <= cmd_addr[31:5];
            len_q  <= cmd_len;
            id_q   <= cmd_id;
            seed_q <= cmd_seed;
            resp_q <= 2'b10;
            mism_q <= 1'b0;
        end else if (state == RESP && data_bvalid) begin
            resp_q <= data_bresp;
            mism_q <= (data_bid != id_q);
        end
    end

endmodule
